// File: rtl/timer_pkg.sv
// timer_pkg: shared encodings and round-robin pick helper for the shared timer
package timer_pkg;
   localparam int CNT_W_DEF = 32;
   localparam int MAX_REQ = 8;
   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN = 1'b1;
   // returns {valid, index}; lowest offset from ptr (with wrap modulo n) wins
   function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr, input int n);
      logic [3:0] r;
      int i;
      r = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         i = int'(ptr) + k;
         i = i >= n ? i - n : i;
         if (k < n && req[i[2:0]]) r = {1'b1, i[2:0]};
      end
      return r;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr
module rr_arbiter
   import timer_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W = $clog2(NUM_REQ)
) (
   input logic [NUM_REQ-1:0] req,
   input logic [PTR_W-1:0] ptr,
   output logic valid,
   output logic [PTR_W-1:0] idx
);
   logic [3:0] pick;
   always_comb pick = rr_pick(MAX_REQ'(req), 3'(ptr), NUM_REQ);
   assign valid = pick[3];
   assign idx = PTR_W'(pick[2:0]);
endmodule

// File: rtl/shared_timer_arbiter.sv
// shared_timer_arbiter: one terminal-count timer shared round-robin between requesters
module shared_timer_arbiter
   import timer_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int CNT_W = CNT_W_DEF,
   parameter int PTR_W = $clog2(NUM_REQ)
) (
   input logic basys_clock,
   input logic rst_n,
   input logic [NUM_REQ-1:0] req,
   input logic [NUM_REQ-1:0] periodic,
   input logic [NUM_REQ*CNT_W-1:0] m_req,
   output logic [NUM_REQ-1:0] grant,
   output logic [NUM_REQ-1:0] done,
   output logic busy,
   output logic [CNT_W-1:0] m_value,
   output logic clk_out
);
   logic state, state_n, mode, mode_n, busy_n, clk_n, win_v, term, abort;
   logic [NUM_REQ-1:0] grant_n, done_n;
   logic [CNT_W-1:0] cnt, cnt_n, m_n;
   logic [PTR_W-1:0] ptr, ptr_n, own, own_n, win, own_inc;
   rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (.req(req), .ptr(ptr), .valid(win_v), .idx(win));
   assign abort = !req[own];
   assign term = cnt == m_value;
   assign own_inc = own == PTR_W'(NUM_REQ - 1) ? '0 : own + 1'b1;
   always_ff @(posedge basys_clock)
      if (!rst_n) begin
         state <= ST_IDLE;
         grant <= '0;
         done <= '0;
         busy <= 1'b0;
         m_value <= '0;
         clk_out <= 1'b0;
         cnt <= '0;
         ptr <= '0;
         own <= '0;
         mode <= 1'b0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         done <= done_n;
         busy <= busy_n;
         m_value <= m_n;
         clk_out <= clk_n;
         cnt <= cnt_n;
         ptr <= ptr_n;
         own <= own_n;
         mode <= mode_n;
      end
   always_comb state_n = state == ST_IDLE ? (win_v ? ST_RUN : ST_IDLE)
                                          : (abort || (term && !mode)) ? ST_IDLE : ST_RUN;
   // abort outranks terminal count, so an aborted grant never sees done
   always_comb begin
      grant_n = grant;
      done_n = '0;
      busy_n = busy;
      m_n = m_value;
      mode_n = mode;
      clk_n = clk_out;
      cnt_n = cnt;
      ptr_n = ptr;
      own_n = own;
      if (state == ST_IDLE) begin
         if (win_v) begin
            grant_n = NUM_REQ'(1) << win;
            busy_n = 1'b1;
            m_n = m_req[win*CNT_W +: CNT_W];
            mode_n = periodic[win];
            cnt_n = '0;
            clk_n = 1'b0;
            own_n = win;
         end
      end else if (abort || (term && !mode)) begin
         done_n = abort ? '0 : grant;
         grant_n = '0;
         busy_n = 1'b0;
         m_n = '0;
         clk_n = 1'b0;
         ptr_n = own_inc;
      end else if (term) begin
         done_n = grant;
         clk_n = !clk_out;
         cnt_n = '0;
      end else cnt_n = cnt + 1'b1;
   end
endmodule
